// File: rtl/phys_free_list_if.sv
// Rename-side handshake bundle for the physical-tag free list.
// The master is the rename/retire logic; the slave is the free list itself.
interface phys_free_list_if #(
  parameter int TAG_W = 6
);
  logic             stall;
  logic             alloc_req;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_gnt;
  logic             free_valid;
  logic [TAG_W-1:0] free_tag;
  logic             commit_alloc;
  logic             flush;
  logic             empty;
  logic [TAG_W-1:0] count;
  logic             overflow;

  modport master (
    output stall, alloc_req, free_valid, free_tag, commit_alloc, flush,
    input  alloc_tag, alloc_gnt, empty, count, overflow
  );

  modport slave (
    input  stall, alloc_req, free_valid, free_tag, commit_alloc, flush,
    output alloc_tag, alloc_gnt, empty, count, overflow
  );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with a speculative head for
// allocation and a committed head so a flush can reclaim squashed tags at once.
module phys_free_list #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  phys_free_list_if.slave fl
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] spec_head_q, spec_head_d;
  logic [PTR_W-1:0] commit_head_q, commit_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             overflow_q, overflow_d;

  logic [PTR_W-1:0] spec_count;
  logic [PTR_W-1:0] commit_count;
  logic             empty;
  logic             alloc_gnt;
  logic             free_live;
  logic             free_ok;
  logic             free_drop;
  logic             commit_ok;
  logic             commit_drop;

  // Pointer differences are modulo 2^PTR_W; the wrap bit separates full from empty.
  assign spec_count   = tail_q - spec_head_q;
  assign commit_count = tail_q - commit_head_q;
  assign empty        = (spec_count == '0);
  assign alloc_gnt    = fl.alloc_req & ~fl.stall & ~fl.flush & ~empty;

  assign fl.empty     = empty;
  assign fl.count     = TAG_W'(spec_count);
  assign fl.alloc_gnt = alloc_gnt;
  assign fl.alloc_tag = mem_q[spec_head_q[IDX_W-1:0]];
  assign fl.overflow  = overflow_q;

  // Tag 0 backs r0, which is never remapped, so a returned 0 is simply ignored.
  assign free_live   = fl.free_valid & (fl.free_tag != '0);
  assign free_ok     = free_live & (commit_count != PTR_FULL);
  assign free_drop   = free_live & (commit_count == PTR_FULL);
  assign commit_ok   = fl.commit_alloc & (commit_head_q != spec_head_q);
  assign commit_drop = fl.commit_alloc & (commit_head_q == spec_head_q);

  always_comb begin
    commit_head_d = commit_head_q;
    spec_head_d   = spec_head_q;
    tail_d        = tail_q;
    overflow_d    = overflow_q | free_drop | commit_drop;

    if (commit_ok) begin
      commit_head_d = commit_head_q + PTR_ONE;
    end
    if (free_ok) begin
      tail_d = tail_q + PTR_ONE;
    end
    // Flush rewinds to the committed head including this cycle's commit.
    if (fl.flush) begin
      spec_head_d = commit_head_d;
    end else if (alloc_gnt) begin
      spec_head_d = spec_head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_FULL;
      overflow_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= TAG_W'(DEPTH + i);
      end
    end else begin
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      overflow_q    <= overflow_d;
      if (free_ok) begin
        mem_q[tail_q[IDX_W-1:0]] <= fl.free_tag;
      end
    end
  end
endmodule

// File: tb/tb_phys_free_list.sv
// Randomized and directed bench for phys_free_list with a queue-based model
// and a scoreboard drained by an independent negedge monitor.
module tb_phys_free_list;
  localparam int DEPTH = 32;
  localparam int TAG_W = 6;

  logic clk;
  logic reset;

  phys_free_list_if #(.TAG_W(TAG_W)) f ();

  phys_free_list #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  gnt;
    int  tag_valid;
    int  tag;
    int  count;
    int  empty;
    int  ovf;
    int  txn;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Model: 'avail' holds every tag between the committed head and the tail in
  // list order; the first n_spec of them are handed out but not yet committed.
  int avail[$];
  int n_spec;
  int ovf_m;

  task automatic model_reset();
    avail = {};
    for (int i = 0; i < DEPTH; i++) avail.push_back(DEPTH + i);
    n_spec = 0;
    ovf_m  = 0;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f.alloc_req = 0; f.stall = 0; f.free_valid = 0; f.free_tag = '0;
    f.commit_alloc = 0; f.flush = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive(input bit req, input bit st, input bit fv, input int ft,
                       input bit cm, input bit fls);
    exp_t e;
    int   cnt;
    bit   free_ok, commit_ok, gnt;
    f.alloc_req    = req;
    f.stall        = st;
    f.free_valid   = fv;
    f.free_tag     = TAG_W'(ft);
    f.commit_alloc = cm;
    f.flush        = fls;

    cnt         = avail.size() - n_spec;
    gnt         = req && !st && !fls && cnt > 0;
    e.gnt       = gnt;
    e.tag_valid = (cnt > 0);
    e.tag       = (cnt > 0) ? avail[n_spec] : 0;
    e.count     = cnt;
    e.empty     = (cnt == 0);
    e.ovf       = ovf_m;
    e.txn       = txn_no++;
    sb.push_back(e);

    commit_ok = cm && n_spec > 0;
    if (cm && !commit_ok) ovf_m = 1;
    free_ok = fv && ft != 0 && avail.size() < DEPTH;
    if (fv && ft != 0 && !free_ok) ovf_m = 1;
    if (commit_ok) begin
      void'(avail.pop_front());
      n_spec--;
    end
    if (free_ok) avail.push_back(ft);
    if (fls) n_spec = 0;
    else if (gnt) n_spec++;

    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whenever a transaction's outputs are on the bus.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("alloc_gnt", int'(f.alloc_gnt), e.gnt);
      chk("count", int'(f.count), e.count);
      chk("empty", int'(f.empty), e.empty);
      chk("overflow", int'(f.overflow), e.ovf);
      if (e.tag_valid) chk("alloc_tag", int'(f.alloc_tag), e.tag);
      $display("txn %0d: gnt=%0d tag=%0d count=%0d empty=%0d ovf=%0d",
               e.txn, f.alloc_gnt, f.alloc_tag, f.count, f.empty, f.overflow);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    f.alloc_req = 0; f.stall = 0; f.free_valid = 0; f.free_tag = '0;
    f.commit_alloc = 0; f.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Drain the list: tags DEPTH..2*DEPTH-1 in order, then one refused request.
    repeat (DEPTH + 1) drive(1, 0, 0, 0, 0, 0);
    // Make room, then a same-cycle free must not satisfy the empty request.
    repeat (4) drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 40, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle();

    // Allocate 5, commit 2, flush: speculative head rewinds to tag 34.
    do_reset();
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);

    // Flush, commit and free together; the free and commit both survive.
    do_reset();
    repeat (3) drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 1, 7, 1, 1);
    idle();
    drive(1, 0, 0, 0, 0, 0);

    // Free into a full list is dropped and sets the sticky overflow flag.
    do_reset();
    drive(0, 0, 1, 9, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    idle();

    // Commit with nothing allocated is dropped and flags overflow.
    do_reset();
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 0);
    idle();

    // Random traffic; long enough for pointers to wrap several times.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bit r, s, v, c, fl_b;
      int t;
      r    = ($urandom_range(0, 9) < 6);
      s    = ($urandom_range(0, 7) < 2);
      c    = ($urandom_range(0, 9) < 5);
      v    = ($urandom_range(0, 9) < 5);
      t    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 63));
      fl_b = ($urandom_range(0, 24) == 0);
      drive(r, s, v, t, c, fl_b);
      if (n == 200) do_reset();
    end
    idle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
